// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of the data memory.
// One transaction per 3 cycles: grant (IDLE), memory access (ACCESS), response strobe (RESP).
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DM_ADDRESS-1:0] addr0,
  input  logic [DM_ADDRESS-1:0] addr1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [2:0]            funct3_0,
  input  logic [2:0]            funct3_1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_W-1:0]     rdata0,
  output logic [DATA_W-1:0]     rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  rr_ptr;
  logic                  r_port;
  logic                  r_we;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [2:0]            r_funct3;
  logic                  r_err;
  logic                  legal;
  logic [DATA_W-1:0]     capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Width/alignment legality of the registered request
  always_comb begin
    legal = 1'b0;
    case (r_funct3)
      3'b000:  legal = 1'b1;
      3'b100:  legal = ~r_we;
      3'b001:  legal = ~r_addr[0];
      3'b101:  legal = ~r_addr[0] & ~r_we;
      3'b010:  legal = (r_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign capture = (legal && !r_we) ? mem_rd : '0;

  always_comb begin
    state_nxt  = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rvalid0    = 1'b0;
    rvalid1    = 1'b0;
    err0       = 1'b0;
    err1       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    mem_funct3 = 3'b000;
    // Everything is gated by reset so a store in flight is never committed
    case (state)
      IDLE: begin
        if (!reset) begin
          if (FIXED_PRIO != 0) begin
            gnt0 = req0;
            gnt1 = req1 & ~req0;
          end else begin
            gnt0 = req0 & (~rr_ptr | ~req1);
            gnt1 = req1 & (rr_ptr | ~req0);
          end
        end
        if (gnt0 || gnt1) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt = RESP;
        if (legal && !reset) begin
          mem_read   = ~r_we;
          mem_write  = r_we;
          mem_a      = r_addr;
          mem_wd     = r_wdata;
          mem_funct3 = r_funct3;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        if (!reset) begin
          rvalid0 = ~r_port;
          rvalid1 = r_port;
          err0    = ~r_port & r_err;
          err1    = r_port & r_err;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= 1'b0;
      r_port   <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= 3'b000;
      r_err    <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        r_port   <= gnt1;
        r_we     <= gnt1 ? we1 : we0;
        r_addr   <= gnt1 ? addr1 : addr0;
        r_wdata  <= gnt1 ? wdata1 : wdata0;
        r_funct3 <= gnt1 ? funct3_1 : funct3_0;
        // The port that just lost (or did not ask) is favoured next time
        rr_ptr   <= gnt0;
      end
      if (state == ACCESS) begin
        r_err <= ~legal;
        if (r_port) begin
          rdata1 <= capture;
        end else begin
          rdata0 <= capture;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed data memory model.
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [2:0]    funct3_0, funct3_1;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rd;

  logic          f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_err0, f_err1;
  logic [DW-1:0] f_rdata0, f_rdata1;
  logic          f_mem_read, f_mem_write;
  logic [AW-1:0] f_mem_a;
  logic [DW-1:0] f_mem_wd;
  logic [2:0]    f_mem_funct3;
  logic [DW-1:0] zero_rd;

  int total = 0;
  int bad   = 0;

  logic [7:0]    mem [512];
  logic          init_mem;
  logic [AW-1:0] a1, a2, a3;

  always #5 clk = ~clk;
  assign zero_rd = '0;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .funct3_0(funct3_0), .funct3_1(funct3_1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .mem_read(mem_read), .mem_write(mem_write),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .funct3_0(funct3_0), .funct3_1(funct3_1), .gnt0(f_gnt0), .gnt1(f_gnt1),
    .rvalid0(f_rvalid0), .rvalid1(f_rvalid1), .rdata0(f_rdata0), .rdata1(f_rdata1),
    .err0(f_err0), .err1(f_err1), .mem_read(f_mem_read), .mem_write(f_mem_write),
    .mem_a(f_mem_a), .mem_wd(f_mem_wd), .mem_funct3(f_mem_funct3), .mem_rd(zero_rd)
  );

  // Memory model: initial byte i holds i ^ 0x5A; little-endian, combinational read
  assign a1 = mem_a + 9'd1;
  assign a2 = mem_a + 9'd2;
  assign a3 = mem_a + 9'd3;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (mem_write) begin
      case (mem_funct3)
        3'b000: mem[mem_a] <= mem_wd[7:0];
        3'b001: begin mem[mem_a] <= mem_wd[7:0]; mem[a1] <= mem_wd[15:8]; end
        3'b010: begin
          mem[mem_a] <= mem_wd[7:0];   mem[a1] <= mem_wd[15:8];
          mem[a2]    <= mem_wd[23:16]; mem[a3] <= mem_wd[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rd = '0;
    if (mem_read) begin
      case (mem_funct3)
        3'b000:  mem_rd = {{24{mem[mem_a][7]}}, mem[mem_a]};
        3'b001:  mem_rd = {{16{mem[a1][7]}}, mem[a1], mem[mem_a]};
        3'b010:  mem_rd = {mem[a3], mem[a2], mem[a1], mem[mem_a]};
        3'b100:  mem_rd = {24'b0, mem[mem_a]};
        3'b101:  mem_rd = {16'b0, mem[a1], mem[mem_a]};
        default: mem_rd = '0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    funct3_0 = 3'b000; funct3_1 = 3'b000;
  endtask

  // Issues one request from IDLE and observes the ACCESS and RESP cycles
  task automatic txn(input bit p, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [2:0] f3,
                     output int wc, output logic acc_rd, output logic acc_wr,
                     output logic early_rv, output logic rv,
                     output logic [DW-1:0] rd, output logic e);
    wc = 0;
    if (!p) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; funct3_0 = f3; end
    else    begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; funct3_1 = f3; end
    @(negedge clk);
    while (!(p ? gnt1 : gnt0) && wc < 20) begin
      tick();
      wc++;
      @(negedge clk);
    end
    tick();
    req0 = 0; req1 = 0;
    @(negedge clk);
    acc_rd   = mem_read;
    acc_wr   = mem_write;
    early_rv = p ? rvalid1 : rvalid0;
    tick();
    @(negedge clk);
    rv = p ? rvalid1 : rvalid0;
    rd = p ? rdata1 : rdata0;
    e  = p ? err1 : err0;
    tick();
  endtask

  task automatic test_reset();
    logic [255:0] v;
    idle_inputs();
    reset = 1; init_mem = 1;
    req0 = 1; req1 = 1; funct3_0 = 3'b010; addr1 = 9'h004; funct3_1 = 3'b010;
    tick();
    init_mem = 0;
    tick();
    @(negedge clk);
    v = 256'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write,
              mem_a, mem_wd, mem_funct3, rdata0, rdata1});
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", v); end
    v = 256'({f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_err0, f_err1, f_mem_read, f_mem_write,
              f_mem_a, f_mem_wd, f_mem_funct3, f_rdata0, f_rdata1});
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_outputs_fp: got %h want 0", v); end
  endtask

  // Both ports request continuously from reset release
  task automatic test_round_robin();
    logic [1:0] exp_rr, exp_fp;
    tick();
    reset = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_rr = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
      exp_fp = (k % 3 != 0) ? 2'b00 : 2'b01;
      total++;
      if ({gnt1, gnt0} !== exp_rr) begin
        bad++; $display("FAIL rr_gnt cycle %0d: got %b want %b", k, {gnt1, gnt0}, exp_rr);
      end
      total++;
      if ({f_gnt1, f_gnt0} !== exp_fp) begin
        bad++; $display("FAIL fixed_gnt cycle %0d: got %b want %b", k, {f_gnt1, f_gnt0}, exp_fp);
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
    tick();
  endtask

  task automatic test_sw_lw();
    int wc; logic ar, aw, erv, rv, e; logic [DW-1:0] rd;
    txn(0, 1, 9'h010, 32'hDEADBEEF, 3'b010, wc, ar, aw, erv, rv, rd, e);
    total++;
    if ({wc[4:0], ar, aw, erv, rv, e} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sw_timing: got wc=%0d rd=%b wr=%b rv_early=%b rv=%b err=%b want 0 0 1 0 1 0",
                      wc, ar, aw, erv, rv, e);
    end
    txn(0, 0, 9'h010, 32'h0, 3'b010, wc, ar, aw, erv, rv, rd, e);
    total++;
    if ({ar, aw, erv, rv, e} !== 5'b10010) begin
      bad++; $display("FAIL lw_timing: got rd=%b wr=%b rv_early=%b rv=%b err=%b", ar, aw, erv, rv, e);
    end
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_lb_lbu();
    int wc; logic ar, aw, erv, rv, e; logic [DW-1:0] rd;
    txn(0, 1, 9'h010, 32'h80FF0000, 3'b010, wc, ar, aw, erv, rv, rd, e);
    txn(1, 0, 9'h013, 32'h0, 3'b000, wc, ar, aw, erv, rv, rd, e);
    total++;
    if ({wc[4:0], rv, e, rd} !== {5'd0, 1'b1, 1'b0, 32'hFFFFFF80}) begin
      bad++; $display("FAIL lb_p1: got wc=%0d rv=%b err=%b data=%h want 0 1 0 ffffff80", wc, rv, e, rd);
    end
    txn(1, 0, 9'h013, 32'h0, 3'b100, wc, ar, aw, erv, rv, rd, e);
    total++;
    if ({wc[4:0], rv, e, rd} !== {5'd0, 1'b1, 1'b0, 32'h00000080}) begin
      bad++; $display("FAIL lbu_p1: got wc=%0d rv=%b err=%b data=%h want 0 1 0 00000080", wc, rv, e, rd);
    end
  endtask

  task automatic test_illegal();
    int wc; logic ar, aw, erv, rv, e; logic [DW-1:0] rd;
    bit            tp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic          tw [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [AW-1:0] ta [4] = '{9'h012, 9'h011, 9'h010, 9'h010};
    logic [2:0]    tf [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0]   word;
    for (int i = 0; i < 4; i++) begin
      txn(tp[i], tw[i], ta[i], 32'h0000ABCD, tf[i], wc, ar, aw, erv, rv, rd, e);
      total++;
      if ({ar, aw, erv, rv, e} !== 5'b00011) begin
        bad++; $display("FAIL illegal_%0d: got rd=%b wr=%b rv_early=%b rv=%b err=%b want 0 0 0 1 1",
                        i, ar, aw, erv, rv, e);
      end
    end
    word = {mem[9'h013], mem[9'h012], mem[9'h011], mem[9'h010]};
    total++;
    if (word !== 32'h80FF0000) begin bad++; $display("FAIL illegal_mem: got %h want 80ff0000", word); end
  endtask

  task automatic test_reset_mid();
    int wc; logic ar, aw, erv, rv, e; logic [DW-1:0] rd;
    logic [255:0] v;
    req0 = 1; we0 = 1; addr0 = 9'h020; wdata0 = 32'h12345678; funct3_0 = 3'b010;
    @(negedge clk);
    total++;
    if (gnt0 !== 1'b1) begin bad++; $display("FAIL rst_mid_gnt: got %b want 1", gnt0); end
    tick();
    idle_inputs();
    reset = 1;
    @(negedge clk);
    total++;
    if (mem_write !== 1'b0) begin bad++; $display("FAIL rst_mid_write: got %b want 0", mem_write); end
    tick();
    reset = 0;
    @(negedge clk);
    v = 256'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write,
              mem_a, mem_wd, mem_funct3, rdata0, rdata1});
    total++;
    if (v !== '0) begin bad++; $display("FAIL rst_mid_outputs: got %h want 0", v); end
    tick();
    @(negedge clk);
    total++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      bad++; $display("FAIL rst_mid_rvalid: got %b want 00", {rvalid0, rvalid1});
    end
    tick();
    txn(0, 0, 9'h020, 32'h0, 3'b010, wc, ar, aw, erv, rv, rd, e);
    total++;
    if ({rv, e, rd} !== {1'b1, 1'b0, 32'h79787B7A}) begin
      bad++; $display("FAIL rst_mid_lw: got rv=%b err=%b data=%h want 1 0 79787b7a", rv, e, rd);
    end
  endtask

  task automatic test_partial();
    int wc; logic ar, aw, erv, rv, e; logic [DW-1:0] rd;
    txn(0, 1, 9'h031, 32'h000000AA, 3'b000, wc, ar, aw, erv, rv, rd, e);
    total++;
    if ({aw, rv, e} !== 3'b110) begin bad++; $display("FAIL sb: got wr=%b rv=%b err=%b want 1 1 0", aw, rv, e); end
    txn(1, 1, 9'h032, 32'h0000BEEF, 3'b001, wc, ar, aw, erv, rv, rd, e);
    total++;
    if ({aw, rv, e} !== 3'b110) begin bad++; $display("FAIL sh: got wr=%b rv=%b err=%b want 1 1 0", aw, rv, e); end
    txn(0, 0, 9'h030, 32'h0, 3'b010, wc, ar, aw, erv, rv, rd, e);
    total++;
    if (rd !== 32'hBEEFAA6A) begin bad++; $display("FAIL partial_lw: got %h want beefaa6a", rd); end
  endtask

  initial begin
    init_mem = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_sw_lw();
    test_lb_lbu();
    test_illegal();
    test_reset_mid();
    test_partial();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the datamemory block.
- Port 0 is the core load/store unit; port 1 is the loader/debug requester.
- Grants one transaction at a time, round-robin, with a fixed 3-cycle request-to-response latency.
- Rejects misaligned or illegal-width accesses with an error response; no memory access is issued for them.

Parameters:
- DM_ADDRESS, 9, data memory byte-address width.
- DATA_W, 32, data width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1  request, held until gnt
- we0, we1  in  1  1 = store, 0 = load
- addr0, addr1  in  DM_ADDRESS  byte address
- wdata0, wdata1  in  DATA_W  store data
- funct3_0, funct3_1  in  3  access width/sign, RISC-V encoding
- gnt0, gnt1  out  1  request accepted this cycle
- rvalid0, rvalid1  out  1  one-cycle response strobe
- rdata0, rdata1  out  DATA_W  load data, valid with rvalid
- err0, err1  out  1  access rejected, valid with rvalid
- mem_read, mem_write  out  1  to datamemory MemRead/MemWrite
- mem_a  out  DM_ADDRESS  to datamemory a
- mem_wd  out  DATA_W  to datamemory wd
- mem_funct3  out  3  to datamemory Funct3
- mem_rd  in  DATA_W  from datamemory rd

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Transitions: IDLE->ACCESS on any grant; ACCESS->RESP always; RESP->IDLE always.
- Reset: state IDLE, rr pointer = port 0 favoured. All outputs 0, including gnt, rvalid, err, rdata, mem_*.
- mem_read and mem_write are additionally gated by ~reset combinationally, so an in-flight store is never committed during a reset cycle.
- Grant: combinational, only in IDLE, at most one gnt high.
  - Round-robin: the favoured port wins if it requests; otherwise the other port wins.
  - After each grant, the favoured port becomes the non-granted port.
  - With FIXED_PRIO=1, port 0 always wins and the pointer is ignored.
- On a grant edge: we, addr, wdata, funct3 and port id are registered. The requester may drop or change req from the next cycle.
- Legality check on the registered request:
  - funct3 000/100: always legal.
  - funct3 001/101: legal if addr[0]=0.
  - funct3 010: legal if addr[1:0]=00.
  - Stores with funct3 100/101, and funct3 011/110/111: illegal.
- ACCESS (cycle N+1 after grant cycle N):
  - If legal: mem_read = ~we, mem_write = we, and mem_a/mem_wd/mem_funct3 are driven from the registered request.
  - If illegal: mem_read = mem_write = 0.
  - At the end of ACCESS, mem_rd is captured into the response register (loads only; stores capture 0).
- RESP (cycle N+2): rvalid of the owning port = 1 for exactly one cycle.
  - rdata = captured value; err = illegal flag.
  - For the other port, rvalid = err = 0 and rdata holds its last value.
- mem_a/mem_wd/mem_funct3 are 0 outside ACCESS or when illegal.
- Throughput: one transaction per 3 cycles. No new grant while in ACCESS/RESP; pending requests wait.
- Simultaneous req0 and req1 in IDLE resolve per the pointer; the loser is granted in the next IDLE, 3 cycles later.
- Reset asserted in ACCESS or RESP: the transaction is dropped, no rvalid is issued, and the FSM returns to IDLE.
- rdata/err are stable only while rvalid is high.

Test Plan:
- Reset, then port 0 SW addr 0x010 data 0xDEADBEEF, then LW addr 0x010:
  - gnt0 in the request cycle, mem_write=1 one cycle later, rvalid0 two cycles after gnt.
  - The load returns rdata0=0xDEADBEEF, err0=0.
- Port 1 LB at addr 0x013 after SW 0x80FF0000 to 0x010 -> rdata1=0xFFFFFF80. LBU on the same address -> 0x00000080.
- req0 and req1 both high continuously from reset:
  - Grants alternate 0,1,0,1 with gnt spacing exactly 3 cycles.
  - With FIXED_PRIO=1, only gnt0 is ever asserted.
- LW at addr 0x012, SH at addr 0x011, and funct3=011 -> err=1, rvalid after 2 cycles, mem_read=mem_write=0 throughout, memory contents unchanged.
- Reset asserted in the ACCESS cycle of SW 0x020 data 0x12345678:
  - mem_write=0 in that cycle; no rvalid; all outputs 0 next cycle.
  - A later LW 0x020 returns the prior contents.
- SB 0xAA to 0x031, then SH 0xBEEF to 0x032, then LW 0x030 -> 0xBEEFAAxx, where xx is the unchanged prior byte.
